// File: rtl/seq_detector_param_if.sv
// Bundle of the serial-detector data, control and result signals.
// The master side drives the bit stream; the slave side is the detector.
interface seq_detector_param_if #(
  parameter int N     = 5,
  parameter int CNT_W = 8
);
  logic             en;
  logic             x;
  logic             load;
  logic [N-1:0]     pat_in;
  logic             count_clr;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic [N-1:0]     pattern;

  modport master (
    output en, x, load, pat_in, count_clr,
    input  y, match_count, pattern
  );

  modport slave (
    input  en, x, load, pat_in, count_clr,
    output y, match_count, pattern
  );
endinterface

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector: sliding N-bit window against a loadable pattern,
// optional overlap, and a saturating match counter.
module seq_detector_param #(
  parameter int           N       = 5,
  parameter logic [N-1:0] PATTERN = 5'b11011,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_detector_param_if.slave bus
);

  localparam int               FW        = $clog2(N + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(N);
  localparam logic [FW-1:0]    FILL_ARM  = FW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [N-1:0]     hist,  hist_d;
  logic [FW-1:0]    fill,  fill_d;
  logic [N-1:0]     pat,   pat_d;
  logic             y_q,   y_d;
  logic [CNT_W-1:0] cnt,   cnt_d;
  logic [N-1:0]     next_hist;
  logic             hit;
  logic             match_now;

  // fill gating keeps a zeroed history from matching before N real bits arrive
  always_comb begin
    next_hist = {hist[N-2:0], bus.x};
    hit       = (next_hist == pat) && (fill >= FILL_ARM);
    match_now = !bus.load && bus.en && hit;

    hist_d = hist;
    fill_d = fill;
    pat_d  = pat;
    y_d    = 1'b0;
    cnt_d  = cnt;

    if (bus.load) begin
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.en) begin
      hist_d = next_hist;
      y_d    = hit;
      if (hit && !OVERLAP)
        fill_d = '0;
      else if (fill != FILL_FULL)
        fill_d = fill + FW'(1);
    end

    if (bus.count_clr)
      cnt_d = match_now ? CNT_ONE : '0;
    else if (match_now && (cnt != CNT_MAX))
      cnt_d = cnt + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
      pat  <= PATTERN;
      y_q  <= 1'b0;
      cnt  <= '0;
    end else begin
      hist <= hist_d;
      fill <= fill_d;
      pat  <= pat_d;
      y_q  <= y_d;
      cnt  <= cnt_d;
    end
  end

  assign bus.y           = y_q;
  assign bus.match_count = cnt;
  assign bus.pattern     = pat;

endmodule
